daq_frame_decoder: RTL and testbench
====================================

# daq_frame_decoder

Receive-side counterpart of the 64-bit DAQ frame builder that packs HPTDC readout into header, payload and trailer words. It consumes the 64-bit word stream, recovers the frame header fields and unpacks each embedded 32-bit HPTDC word into decoded hit and error records. It also checks frame integrity against the trailer word count. It sits at the front of the back-end/USB-side analysis path, directly downstream of the frame transport.

## Interface
Parameters:
- MAX_WORDS, 128, maximum payload words per frame; valid range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_data  in  64  frame word
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- hdr_valid  out  1  one-cycle pulse; hdr_* fields updated this cycle
- hdr_trigger_type  out  4  header [59:56]
- hdr_lv1  out  24  header [55:32]
- hdr_bx  out  12  header [31:20]
- hdr_fec_id  out  12  header [19:8]
- hdr_fov  out  4  header [7:4]
- hdr_h  out  1  header [3]
- hdr_d  out  2  header [1:0]
- hit_valid  out  1  decoded hit present; held until hit_ready
- hit_ready  in  1  downstream accepts hit
- hit_tdc_id  out  4  HPTDC word [27:24]
- hit_channel  out  3  HPTDC word [23:21]
- hit_trailing  out  1  0 = leading edge (type 4'b0100), 1 = trailing edge (type 4'b0101)
- hit_time  out  19  HPTDC word [18:0]
- tdc_err_valid  out  1  one-cycle pulse on HPTDC error word (type 4'b0110)
- tdc_err_flags  out  15  HPTDC word [14:0]
- frame_done  out  1  one-cycle pulse on trailer acceptance or frame abort
- frame_ok  out  1  qualifies frame_done; 1 = no error in the frame
- proto_err_cnt  out  16  saturating count of protocol errors

## Operation
- Word formats:
  - Header: [63:60] = 4'hA.
  - Payload: [63:60] = 4'h0, [59:52] = word index, [51:32] reserved, [31:0] = HPTDC word.
  - Trailer: [63:60] = 4'h5, [11:0] = payload word count.
- FSM states are IDLE, PAYLOAD and DRAIN.
  - IDLE: a header moves to PAYLOAD. It latches the hdr_* fields, pulses hdr_valid and clears the word counter. Any other word is dropped and counts as a protocol error.
  - PAYLOAD, payload word: the word counter increments, then the HPTDC type field [31:28] is decoded.
    - 4'b0100 or 4'b0101: present a hit.
    - 4'b0110: pulse tdc_err_valid.
    - 4'b0001, 4'b0010: header and trailer; consumed and not forwarded.
    - Other codes: ignored.
  - PAYLOAD, trailer: go to IDLE and pulse frame_done. frame_ok = 1 only if [11:0] equals the counter and no error occurred in the frame. A count mismatch is a protocol error.
  - PAYLOAD, header: abort the frame with frame_done=1 and frame_ok=0. Count a protocol error, then start the new frame as in IDLE.
  - PAYLOAD, payload word when counter == MAX_WORDS: protocol error, frame_done=1, frame_ok=0, go to DRAIN.
  - DRAIN: drop all words until a header arrives, then act as in IDLE.
  - Unknown marker in PAYLOAD: protocol error, drop the word, stay in PAYLOAD, frame marked bad.
- proto_err_cnt saturates at 16'hFFFF. It is cleared only by rst.
- Reset values: every output is 0, the FSM is in IDLE, counters are 0. in_ready = 1 after reset.
- rst mid-frame discards the partial frame with no frame_done pulse.

## Timing
- in_ready = !hit_valid || hit_ready. It is combinational and must not depend on in_valid.
- All outputs are registered with 1-cycle latency from acceptance: hdr_*, hit_*, tdc_err_*, frame_done.
- hit_valid stays high with stable hit_* fields until hit_ready is sampled high. Back-to-back hits are sustained at one per cycle while hit_ready=1.
- A stalled hit blocks acceptance of all word types, so frame ordering is preserved.
- frame_done and hdr_valid can pulse in the same cycle on a header abort. frame_done refers to the old frame; hdr_* refers to the new one.

## Configuration
- FRAME_SEQ_CHECK_EN defined: payload [59:52] must equal the expected index, which starts at 0 per frame and wraps modulo 256.
  - On mismatch: protocol error and the frame is marked bad (frame_ok=0 at frame_done).
  - Decoding continues, and the expected index resyncs to received index + 1.
- FRAME_SEQ_CHECK_EN undefined: index bits are ignored and no sequence errors are generated.

## Structure
- Package daq_frame_pkg holds:
  - marker constants 4'hA, 4'h0 and 4'h5;
  - HPTDC type codes 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110;
  - the FSM state enum;
  - field widths.
- Sub-module hptdc_word_decode is purely combinational. It takes a 32-bit word and outputs is_hit, is_trailing, is_err, tdc_id, channel, time and flags. It is reusable by the future direct-HPTDC monitor.

## Test plan
- Header 64'hA5000123_0450A0E2, 3 leading hits, trailer count 3 -> hdr_valid once with lv1=24'h000123, bx=12'h045, fec_id=12'h0A0, fov=4'hE, d=2'b10; 3 hits in order; frame_done=1 with frame_ok=1; proto_err_cnt=0.
- Same frame with hit_ready held low for 5 cycles at the second hit -> in_ready low for the stall and hit fields stable; no words lost; frame_ok=1.
- Trailer count 4 for 3 payload words -> frame_done=1, frame_ok=0, proto_err_cnt=1.
- Header, 2 payload words, then a new header -> frame_done=1 with frame_ok=0 and hdr_valid in the same cycle; proto_err_cnt=1.
- MAX_WORDS=4 and 6 payload words -> frame_done/frame_ok=0 at the 5th word; the 6th word and trailer are dropped; the next header decodes normally.
- FRAME_SEQ_CHECK_EN with indices 0,1,3 -> one protocol error and frame_ok=0. Without the macro, the same stimulus gives frame_ok=1.

Source files
------------

// File: rtl/daq_frame_pkg.sv
// daq_frame_pkg: shared marker codes, HPTDC type codes, FSM state and field widths
package daq_frame_pkg;
    localparam int DATA_W  = 64;
    localparam int HPTDC_W = 32;
    localparam int TIME_W  = 19;
    localparam int FLAGS_W = 15;
    localparam int CNT_W   = 8;
    localparam logic [3:0] MRK_HDR = 4'hA;
    localparam logic [3:0] MRK_PAY = 4'h0;
    localparam logic [3:0] MRK_TRL = 4'h5;
    localparam logic [3:0] T_HDR   = 4'b0001;
    localparam logic [3:0] T_TRL   = 4'b0010;
    localparam logic [3:0] T_LEAD  = 4'b0100;
    localparam logic [3:0] T_TRAIL = 4'b0101;
    localparam logic [3:0] T_ERR   = 4'b0110;
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DRAIN} state_t;
endpackage

// File: rtl/daq_frame_decoder_hptdc.sv
// hptdc_word_decode: combinational classifier/unpacker for one 32-bit HPTDC readout word
module hptdc_word_decode
    import daq_frame_pkg::*;
(
    input  logic [HPTDC_W-1:0] i_word,
    output logic               o_is_hit,
    output logic               o_is_trailing,
    output logic               o_is_err,
    output logic               o_is_ctrl,
    output logic [3:0]         o_tdc_id,
    output logic [2:0]         o_channel,
    output logic [TIME_W-1:0]  o_time,
    output logic [FLAGS_W-1:0] o_flags
);
    logic [3:0] w_type;
    logic       w_unused;
    assign w_type        = i_word[31:28];
    assign o_is_hit      = (w_type == T_LEAD) || (w_type == T_TRAIL);
    assign o_is_trailing = w_type == T_TRAIL;
    assign o_is_err      = w_type == T_ERR;
    assign o_is_ctrl     = (w_type == T_HDR) || (w_type == T_TRL);
    assign o_tdc_id      = i_word[27:24];
    assign o_channel     = i_word[23:21];
    assign o_time        = i_word[TIME_W-1:0];
    assign o_flags       = i_word[FLAGS_W-1:0];
    assign w_unused      = ^i_word[20:19];
endmodule

// File: rtl/daq_frame_decoder.sv
// daq_frame_decoder: unpacks 64-bit DAQ frames into header fields, HPTDC hits and error records.
// Optional FRAME_SEQ_CHECK_EN enables payload index sequence checking.
module daq_frame_decoder
    import daq_frame_pkg::*;
#(
    parameter int MAX_WORDS = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               hdr_valid,
    output logic [3:0]         hdr_trigger_type,
    output logic [23:0]        hdr_lv1,
    output logic [11:0]        hdr_bx,
    output logic [11:0]        hdr_fec_id,
    output logic [3:0]         hdr_fov,
    output logic               hdr_h,
    output logic [1:0]         hdr_d,
    output logic               hit_valid,
    input  logic               hit_ready,
    output logic [3:0]         hit_tdc_id,
    output logic [2:0]         hit_channel,
    output logic               hit_trailing,
    output logic [TIME_W-1:0]  hit_time,
    output logic               tdc_err_valid,
    output logic [FLAGS_W-1:0] tdc_err_flags,
    output logic               frame_done,
    output logic               frame_ok,
    output logic [15:0]        proto_err_cnt
);
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bad;
    logic               w_acc, w_hdr, w_pay, w_trl, w_full, w_cnt_eq, w_perr, w_seq_err;
    logic               w_is_hit, w_is_trailing, w_is_err, w_is_ctrl, w_unused;
    logic [3:0]         w_tdc_id;
    logic [2:0]         w_channel;
    logic [TIME_W-1:0]  w_time;
    logic [FLAGS_W-1:0] w_flags;
`ifdef FRAME_SEQ_CHECK_EN
    logic [7:0]         r_seq;
    assign w_seq_err = in_data[59:52] != r_seq;
`else
    assign w_seq_err = 1'b0;
`endif
    assign in_ready = !hit_valid || hit_ready;
    assign w_acc    = in_valid && in_ready;
    assign w_hdr    = in_data[63:60] == MRK_HDR;
    assign w_pay    = in_data[63:60] == MRK_PAY;
    assign w_trl    = in_data[63:60] == MRK_TRL;
    assign w_full   = r_cnt == CNT_W'(MAX_WORDS);
    assign w_cnt_eq = in_data[11:0] == {{(12-CNT_W){1'b0}}, r_cnt};
    assign w_unused = ^{in_data[2], w_is_ctrl};
    // Every accepted word that breaks framing rules bumps the protocol error counter
    always_comb begin
        w_perr = 1'b0;
        if (w_acc)
            w_perr = (r_state == S_IDLE)    ? !w_hdr :
                     (r_state == S_PAYLOAD) ? (w_hdr || (w_pay ? (w_full || w_seq_err) :
                                                         w_trl ? !w_cnt_eq : 1'b1)) : 1'b0;
    end
    hptdc_word_decode u_dec (
        .i_word        (in_data[HPTDC_W-1:0]),
        .o_is_hit      (w_is_hit),
        .o_is_trailing (w_is_trailing),
        .o_is_err      (w_is_err),
        .o_is_ctrl     (w_is_ctrl),
        .o_tdc_id      (w_tdc_id),
        .o_channel     (w_channel),
        .o_time        (w_time),
        .o_flags       (w_flags)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_bad            <= 1'b0;
`ifdef FRAME_SEQ_CHECK_EN
            r_seq            <= '0;
`endif
            hdr_valid        <= 1'b0;
            hdr_trigger_type <= '0;
            hdr_lv1          <= '0;
            hdr_bx           <= '0;
            hdr_fec_id       <= '0;
            hdr_fov          <= '0;
            hdr_h            <= 1'b0;
            hdr_d            <= '0;
            hit_valid        <= 1'b0;
            hit_tdc_id       <= '0;
            hit_channel      <= '0;
            hit_trailing     <= 1'b0;
            hit_time         <= '0;
            tdc_err_valid    <= 1'b0;
            tdc_err_flags    <= '0;
            frame_done       <= 1'b0;
            frame_ok         <= 1'b0;
            proto_err_cnt    <= '0;
        end else begin
            hdr_valid     <= 1'b0;
            tdc_err_valid <= 1'b0;
            frame_done    <= 1'b0;
            if (hit_valid && hit_ready)
                hit_valid <= 1'b0;
            if (w_perr && proto_err_cnt != 16'hFFFF)
                proto_err_cnt <= proto_err_cnt + 16'd1;
            if (w_acc && w_hdr) begin
                // A header inside a frame closes the old frame as bad in the same cycle
                if (r_state == S_PAYLOAD) begin
                    frame_done <= 1'b1;
                    frame_ok   <= 1'b0;
                end
                hdr_valid        <= 1'b1;
                hdr_trigger_type <= in_data[59:56];
                hdr_lv1          <= in_data[55:32];
                hdr_bx           <= in_data[31:20];
                hdr_fec_id       <= in_data[19:8];
                hdr_fov          <= in_data[7:4];
                hdr_h            <= in_data[3];
                hdr_d            <= in_data[1:0];
                r_cnt            <= '0;
                r_bad            <= 1'b0;
`ifdef FRAME_SEQ_CHECK_EN
                r_seq            <= '0;
`endif
                r_state          <= S_PAYLOAD;
            end else if (w_acc && r_state == S_PAYLOAD) begin
                if (w_trl) begin
                    frame_done <= 1'b1;
                    frame_ok   <= !r_bad && w_cnt_eq;
                    r_state    <= S_IDLE;
                end else if (w_pay && w_full) begin
                    frame_done <= 1'b1;
                    frame_ok   <= 1'b0;
                    r_state    <= S_DRAIN;
                end else if (w_pay) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_seq_err)
                        r_bad <= 1'b1;
`ifdef FRAME_SEQ_CHECK_EN
                    r_seq <= in_data[59:52] + 8'd1;
`endif
                    if (w_is_hit) begin
                        hit_valid    <= 1'b1;
                        hit_tdc_id   <= w_tdc_id;
                        hit_channel  <= w_channel;
                        hit_trailing <= w_is_trailing;
                        hit_time     <= w_time;
                    end
                    if (w_is_err) begin
                        tdc_err_valid <= 1'b1;
                        tdc_err_flags <= w_flags;
                    end
                end else begin
                    r_bad <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_daq_frame_decoder.sv
// tb_daq_frame_decoder: directed frames with a queue scoreboard checked by an output monitor
module tb_daq_frame_decoder;
    localparam int MW = 4;
    localparam logic [63:0] H1 = 64'hA5000123_0450A0E2;
    localparam logic [63:0] H2 = 64'hA3ABCDEF_12345678;
    localparam logic [58:0] E1 = {4'h5, 24'h000123, 12'h045, 12'h0A0, 4'hE, 1'b0, 2'b10};
    localparam logic [58:0] E2 = {4'h3, 24'hABCDEF, 12'h123, 12'h456, 4'h7, 1'b1, 2'b00};
    logic clk, rst, in_valid, in_ready, hit_ready;
    logic [63:0] in_data;
    logic hdr_valid, hdr_h, hit_valid, hit_trailing, tdc_err_valid, frame_done, frame_ok;
    logic [3:0] hdr_trigger_type, hdr_fov, hit_tdc_id;
    logic [23:0] hdr_lv1;
    logic [11:0] hdr_bx, hdr_fec_id;
    logic [1:0] hdr_d;
    logic [2:0] hit_channel;
    logic [18:0] hit_time;
    logic [14:0] tdc_err_flags;
    logic [15:0] proto_err_cnt;
    int checks = 0, errors = 0;
    int hits_seen = 0, both_cnt = 0, stall_cnt = 0, stall_left = 0, stall_at = -1;
    logic [58:0] q_hdr[$];
    logic [26:0] q_hit[$];
    logic        q_fd[$];
    logic [14:0] q_err[$];
    logic        prev_stall = 1'b0;
    logic [26:0] prev_hit = '0;

    daq_frame_decoder #(.MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .hdr_valid(hdr_valid), .hdr_trigger_type(hdr_trigger_type), .hdr_lv1(hdr_lv1),
        .hdr_bx(hdr_bx), .hdr_fec_id(hdr_fec_id), .hdr_fov(hdr_fov), .hdr_h(hdr_h), .hdr_d(hdr_d),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_tdc_id(hit_tdc_id),
        .hit_channel(hit_channel), .hit_trailing(hit_trailing), .hit_time(hit_time),
        .tdc_err_valid(tdc_err_valid), .tdc_err_flags(tdc_err_flags),
        .frame_done(frame_done), .frame_ok(frame_ok), .proto_err_cnt(proto_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: output pulse with nothing expected", nm);
    endtask

    function automatic logic [63:0] pw(input logic [7:0] idx, input logic [31:0] h);
        return {4'h0, idx, 20'h0, h};
    endfunction
    function automatic logic [31:0] lead(input logic [3:0] t, input logic [2:0] c, input logic [18:0] tm);
        return {4'b0100, t, c, 2'b00, tm};
    endfunction
    function automatic logic [31:0] trail(input logic [3:0] t, input logic [2:0] c, input logic [18:0] tm);
        return {4'b0101, t, c, 2'b00, tm};
    endfunction
    function automatic logic [63:0] tr(input logic [11:0] n);
        return {4'h5, 48'h0, n};
    endfunction

    task automatic send(input logic [63:0] w);
        int t;
        in_data  = w;
        in_valid = 1'b1;
        t = 0;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) unexpected("send_timeout");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic frame3(input logic [63:0] h, input logic [58:0] eh, input logic [11:0] n, input logic ok);
        q_hdr.push_back(eh);
        q_hit.push_back({4'h1, 3'h2, 1'b0, 19'h00100});
        q_hit.push_back({4'h3, 3'h5, 1'b0, 19'h7FFFF});
        q_hit.push_back({4'hF, 3'h7, 1'b0, 19'h12345});
        q_fd.push_back(ok);
        send(h);
        send(pw(8'd0, lead(4'h1, 3'h2, 19'h00100)));
        send(pw(8'd1, lead(4'h3, 3'h5, 19'h7FFFF)));
        send(pw(8'd2, lead(4'hF, 3'h7, 19'h12345)));
        send(tr(n));
        settle();
    endtask

    always begin
        @(negedge clk);
        if (stall_left > 0 && hit_valid && hits_seen == stall_at) begin
            hit_ready = 1'b0;
            stall_left--;
        end else begin
            hit_ready = 1'b1;
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (hdr_valid) begin
                if (q_hdr.size() == 0) unexpected("hdr");
                else chk("hdr", 64'({hdr_trigger_type, hdr_lv1, hdr_bx, hdr_fec_id, hdr_fov, hdr_h, hdr_d}), 64'(q_hdr.pop_front()));
            end
            if (frame_done) begin
                if (hdr_valid) both_cnt++;
                if (q_fd.size() == 0) unexpected("frame_done");
                else chk("frame_ok", 64'(frame_ok), 64'(q_fd.pop_front()));
            end
            if (tdc_err_valid) begin
                if (q_err.size() == 0) unexpected("tdc_err");
                else chk("tdc_err_flags", 64'(tdc_err_flags), 64'(q_err.pop_front()));
            end
            if (prev_stall) chk("hit_stable", 64'({hit_tdc_id, hit_channel, hit_trailing, hit_time}), 64'(prev_hit));
            if (hit_valid && !hit_ready) begin
                stall_cnt++;
                chk("in_ready_stall", 64'(in_ready), 64'(0));
            end
            if (hit_valid && hit_ready) begin
                hits_seen++;
                if (q_hit.size() == 0) unexpected("hit");
                else chk("hit", 64'({hit_tdc_id, hit_channel, hit_trailing, hit_time}), 64'(q_hit.pop_front()));
            end
            prev_stall = hit_valid && !hit_ready;
            prev_hit   = {hit_tdc_id, hit_channel, hit_trailing, hit_time};
        end
    end

    initial begin
        int pe;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_outputs", 64'({hdr_valid, hit_valid, tdc_err_valid, frame_done, frame_ok, proto_err_cnt}), 64'(0));
        chk("rst_fields", 64'({hdr_lv1, hit_time, tdc_err_flags}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        pe = 0;

        frame3(H1, E1, 12'd3, 1'b1);
        chk("proto_clean", 64'(proto_err_cnt), 64'(pe));

        q_hdr.push_back(E2);
        q_hit.push_back({4'h2, 3'h1, 1'b1, 19'h0ABCD});
        q_err.push_back(15'h2A5B);
        q_fd.push_back(1'b1);
        send(H2);
        send(pw(8'd0, trail(4'h2, 3'h1, 19'h0ABCD)));
        send(pw(8'd1, {4'b0110, 13'h0, 15'h2A5B}));
        send(pw(8'd2, 32'h1000_0000));
        send(pw(8'd3, 32'h3FFF_FFFF));
        send(tr(12'd4));
        settle();
        chk("proto_mixed", 64'(proto_err_cnt), 64'(pe));

        stall_cnt = 0;
        stall_at = hits_seen + 1;
        stall_left = 5;
        frame3(H1, E1, 12'd3, 1'b1);
        chk("stall_cycles", 64'(stall_cnt), 64'(5));

        frame3(H1, E1, 12'd4, 1'b0);
        pe++;
        chk("proto_count_mismatch", 64'(proto_err_cnt), 64'(pe));

        q_hdr.push_back(E1);
        q_hit.push_back({4'h4, 3'h0, 1'b0, 19'h00011});
        q_hit.push_back({4'h4, 3'h1, 1'b0, 19'h00022});
        q_fd.push_back(1'b0);
        q_hdr.push_back(E2);
        q_hit.push_back({4'h4, 3'h2, 1'b0, 19'h00033});
        q_fd.push_back(1'b1);
        send(H1);
        send(pw(8'd0, lead(4'h4, 3'h0, 19'h00011)));
        send(pw(8'd1, lead(4'h4, 3'h1, 19'h00022)));
        send(H2);
        send(pw(8'd0, lead(4'h4, 3'h2, 19'h00033)));
        send(tr(12'd1));
        settle();
        pe++;
        chk("proto_abort", 64'(proto_err_cnt), 64'(pe));
        chk("abort_same_cycle", 64'(both_cnt), 64'(1));

        q_hdr.push_back(E1);
        for (int i = 0; i < 4; i++) q_hit.push_back({4'h6, 3'(i), 1'b0, 19'(i + 16)});
        q_fd.push_back(1'b0);
        send(H1);
        for (int i = 0; i < 6; i++) send(pw(8'(i), lead(4'h6, 3'(i), 19'(i + 16))));
        send(tr(12'd6));
        settle();
        pe++;
        chk("proto_overflow", 64'(proto_err_cnt), 64'(pe));
        q_hdr.push_back(E2);
        q_hit.push_back({4'h7, 3'h3, 1'b1, 19'h40000});
        q_fd.push_back(1'b1);
        send(H2);
        send(pw(8'd0, trail(4'h7, 3'h3, 19'h40000)));
        send(tr(12'd1));
        settle();
        chk("proto_after_drain", 64'(proto_err_cnt), 64'(pe));

        q_hdr.push_back(E1);
        q_hit.push_back({4'h8, 3'h0, 1'b0, 19'h00001});
        q_hit.push_back({4'h8, 3'h1, 1'b0, 19'h00002});
        q_hit.push_back({4'h8, 3'h2, 1'b0, 19'h00003});
`ifdef FRAME_SEQ_CHECK_EN
        q_fd.push_back(1'b0);
        pe++;
`else
        q_fd.push_back(1'b1);
`endif
        send(H1);
        send(pw(8'd0, lead(4'h8, 3'h0, 19'h00001)));
        send(pw(8'd1, lead(4'h8, 3'h1, 19'h00002)));
        send(pw(8'd3, lead(4'h8, 3'h2, 19'h00003)));
        send(tr(12'd3));
        settle();
        chk("proto_seq", 64'(proto_err_cnt), 64'(pe));

        send(tr(12'd0));
        pe++;
        chk("proto_idle_trailer", 64'(proto_err_cnt), 64'(pe));
        send(pw(8'd0, lead(4'h1, 3'h1, 19'h1)));
        pe++;
        chk("proto_idle_payload", 64'(proto_err_cnt), 64'(pe));

        q_hdr.push_back(E2);
        q_hit.push_back({4'h9, 3'h4, 1'b0, 19'h5A5A5});
        q_fd.push_back(1'b0);
        send(H2);
        send(pw(8'd0, lead(4'h9, 3'h4, 19'h5A5A5)));
        send(64'hF000_0000_0000_0000);
        send(tr(12'd1));
        settle();
        pe++;
        chk("proto_unknown_marker", 64'(proto_err_cnt), 64'(pe));

        q_hdr.push_back(E1);
        q_hit.push_back({4'hA, 3'h5, 1'b0, 19'h00077});
        send(H1);
        send(pw(8'd0, lead(4'hA, 3'h5, 19'h00077)));
        settle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_mid_proto", 64'(proto_err_cnt), 64'(0));
        chk("rst_mid_done", 64'({frame_done, hit_valid, in_ready}), 64'(3'b001));
        @(negedge clk);
        q_hdr.push_back(E2);
        q_hit.push_back({4'hB, 3'h6, 1'b1, 19'h00099});
        q_fd.push_back(1'b1);
        send(H2);
        send(pw(8'd0, trail(4'hB, 3'h6, 19'h00099)));
        send(tr(12'd1));
        settle();
        chk("proto_final", 64'(proto_err_cnt), 64'(0));
        chk("queues_empty", 64'(q_hdr.size() + q_hit.size() + q_fd.size() + q_err.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
